// File: rtl/seg7_pkg.sv
// Shared types and segment codes for the seg7_scan_n multiplexed display driver.
// Segment bit order: bit 7 = dp, bits 6..0 = g..a, active high.
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_0     = 8'h3F;
    localparam seg_t SEG_1     = 8'h06;
    localparam seg_t SEG_2     = 8'h5B;
    localparam seg_t SEG_3     = 8'h4F;
    localparam seg_t SEG_4     = 8'h66;
    localparam seg_t SEG_5     = 8'h6D;
    localparam seg_t SEG_6     = 8'h7D;
    localparam seg_t SEG_7     = 8'h07;
    localparam seg_t SEG_8     = 8'h7F;
    localparam seg_t SEG_9     = 8'h6F;
    localparam seg_t SEG_A     = 8'h77;
    localparam seg_t SEG_B     = 8'h7C;
    localparam seg_t SEG_C     = 8'h39;
    localparam seg_t SEG_D     = 8'h5E;
    localparam seg_t SEG_E     = 8'h79;
    localparam seg_t SEG_F     = 8'h71;
    localparam seg_t SEG_BLANK = 8'h00;
    localparam seg_t SEG_DP    = 8'h80;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to 7-segment decoder (g..a). Hex digits A-F are decoded only when
// SEG7_HEX_EN is defined; otherwise they produce an unlit pattern (BCD-only build).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK[6:0];
        case (nib)
            4'h0: seg = SEG_0[6:0];
            4'h1: seg = SEG_1[6:0];
            4'h2: seg = SEG_2[6:0];
            4'h3: seg = SEG_3[6:0];
            4'h4: seg = SEG_4[6:0];
            4'h5: seg = SEG_5[6:0];
            4'h6: seg = SEG_6[6:0];
            4'h7: seg = SEG_7[6:0];
            4'h8: seg = SEG_8[6:0];
            4'h9: seg = SEG_9[6:0];
`ifdef SEG7_HEX_EN
            4'hA: seg = SEG_A[6:0];
            4'hB: seg = SEG_B[6:0];
            4'hC: seg = SEG_C[6:0];
            4'hD: seg = SEG_D[6:0];
            4'hE: seg = SEG_E[6:0];
            4'hF: seg = SEG_F[6:0];
`endif
            default: seg = SEG_BLANK[6:0];
        endcase
    end

endmodule

// File: rtl/seg7_scan_n.sv
// Multiplexed DIGITS-position seven-segment driver with frame snapshot, leading-zero
// blanking, per-digit dp and 16-level PWM. Optional hex decode: define SEG7_HEX_EN.
module seg7_scan_n
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   display_num,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    output logic [DIGITS-1:0]     dtube_cs_n,
    output logic [7:0]            dtube_data,
    output logic                  frame_tick
);

    localparam int PW   = $clog2(SCAN_DIV);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int STEP = SCAN_DIV / 16;

    logic [PW-1:0]         p_q, p_d;
    logic [IW-1:0]         i_q, i_d;
    logic [4*DIGITS-1:0]   s_num_q, s_num_d;
    logic [DIGITS-1:0]     s_dp_q, s_dp_d;
    logic                  s_blz_q, s_blz_d;
    logic [3:0]            s_bright_q, s_bright_d;
    logic [DIGITS-1:0]     cs_q, cs_d;
    seg_t                  data_q, data_d;
    logic                  tick_q, tick_d;

    logic                  wrap_p, last_i, load;
    logic [DIGITS-1:0]     sel;
    logic [DIGITS-1:0]     blank_vec;
    logic [3:0]            nib_cur;
    logic                  dp_cur, blank_cur, lit, upper_zero;
    logic [31:0]           on_cyc;
    logic [6:0]            seg_cur;

    seg7_decode u_dec (
        .nib (nib_cur),
        .seg (seg_cur)
    );

    // Scan counters and frame snapshot; the snapshot only moves on the frame boundary
    always_comb begin
        wrap_p     = (p_q == PW'(SCAN_DIV - 1));
        last_i     = (i_q == IW'(DIGITS - 1));
        load       = wrap_p && last_i;
        p_d        = wrap_p ? '0 : p_q + 1'b1;
        i_d        = i_q;
        if (wrap_p)
            i_d = last_i ? '0 : i_q + 1'b1;
        s_num_d    = load ? display_num : s_num_q;
        s_dp_d     = load ? dp_in       : s_dp_q;
        s_blz_d    = load ? blank_lz    : s_blz_q;
        s_bright_d = load ? brightness  : s_bright_q;
        tick_d     = load;
    end

    // A digit is blanked when it and every digit above it is zero; units never blanks
    always_comb begin
        upper_zero = 1'b1;
        blank_vec  = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            upper_zero   = upper_zero && (s_num_q[4*d +: 4] == 4'h0);
            blank_vec[d] = (d > 0) && s_blz_q && upper_zero;
        end
    end

    always_comb begin
        sel       = '0;
        nib_cur   = 4'h0;
        dp_cur    = 1'b0;
        blank_cur = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (i_q == IW'(d)) begin
                sel[d]    = 1'b1;
                nib_cur   = s_num_q[4*d +: 4];
                dp_cur    = s_dp_q[d];
                blank_cur = blank_vec[d];
            end
        end
    end

    // p == 0 stays dark so the previous digit's segments never ghost onto the new one
    always_comb begin
        on_cyc = (32'(s_bright_q) + 32'd1) * 32'(STEP);
        lit    = (p_q != '0) && (32'(p_q) < on_cyc);
        cs_d   = '1;
        data_d = SEG_BLANK;
        if (lit) begin
            if (!blank_cur) begin
                cs_d   = ~sel;
                data_d = {dp_cur, seg_cur};
            end else if (dp_cur) begin
                cs_d   = ~sel;
                data_d = SEG_DP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q        <= '0;
            i_q        <= '0;
            s_num_q    <= '0;
            s_dp_q     <= '0;
            s_blz_q    <= 1'b0;
            s_bright_q <= 4'h0;
            cs_q       <= '1;
            data_q     <= SEG_BLANK;
            tick_q     <= 1'b0;
        end else begin
            p_q        <= p_d;
            i_q        <= i_d;
            s_num_q    <= s_num_d;
            s_dp_q     <= s_dp_d;
            s_blz_q    <= s_blz_d;
            s_bright_q <= s_bright_d;
            cs_q       <= cs_d;
            data_q     <= data_d;
            tick_q     <= tick_d;
        end
    end

    assign dtube_cs_n = cs_q;
    assign dtube_data = data_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_n.sv
// Randomized and directed bench for seg7_scan_n (DIGITS=4, SCAN_DIV=16) against a
// cycle-count based reference model.
module tb_seg7_scan_n;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] display_num = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  brightness = 4'h0;
    logic [3:0]  dtube_cs_n;
    logic [7:0]  dtube_data;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;

    seg7_scan_n #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .display_num (display_num),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .brightness  (brightness),
        .dtube_cs_n  (dtube_cs_n),
        .dtube_data  (dtube_data),
        .frame_tick  (frame_tick)
    );

    always #5 clk = ~clk;

`ifdef SEG7_HEX_EN
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`else
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
`endif

    // Reference model: position derived from cycles since reset, snapshot at frame end
    int          mn, mp, md, on_cyc;
    logic [15:0] sn;
    logic [3:0]  sdp;
    bit          sblz, lit, blank;
    int          sbr;
    logic [3:0]  ecs;
    logic [7:0]  edata;
    bit          etick;

    always @(posedge clk) begin
        if (rst) begin
            mn = 0; sn = 0; sdp = 0; sblz = 0; sbr = 0;
            ecs = 4'hF; edata = 8'h00; etick = 0;
        end else begin
            mp     = mn % SCAN_DIV;
            md     = (mn / SCAN_DIV) % DIGITS;
            on_cyc = (sbr + 1) * (SCAN_DIV / 16);
            lit    = (mp >= 1) && (mp < on_cyc);
            blank  = (md > 0) && sblz && ((sn >> (4 * md)) == 16'h0);
            ecs    = 4'hF;
            edata  = 8'h00;
            if (lit && !blank) begin
                ecs[md] = 1'b0;
                edata   = {sdp[md], seg_tab[(sn >> (4 * md)) & 16'hF]};
            end else if (lit && sdp[md]) begin
                ecs[md] = 1'b0;
                edata   = 8'h80;
            end
            etick = (mp == SCAN_DIV - 1) && (md == DIGITS - 1);
            if (etick) begin
                sn = display_num; sdp = dp_in; sblz = blank_lz; sbr = int'(brightness);
            end
            mn++;
        end
    end

    task automatic wait_tick(output bit ok);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (frame_tick) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dtube_cs_n !== 4'hF || dtube_data !== 8'h00 || frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL reset_state got cs=%b data=%h tick=%b want cs=1111 data=00 tick=0",
                         dtube_cs_n, dtube_data, frame_tick);
            end
        end
        rst = 1'b0;
        // Snapshot brightness is 0 after reset; with a 16-cycle slot that is ON_CYC=1
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            checks++;
            if ({dtube_cs_n, dtube_data, frame_tick} !== {ecs, edata, etick}) begin
                failures++;
                $display("FAIL first_frame k=%0d got cs=%b data=%h tick=%b want cs=%b data=%h tick=%b",
                         k, dtube_cs_n, dtube_data, frame_tick, ecs, edata, etick);
            end
        end
    endtask

    task automatic test_scan();
        bit ok;
        int cnt [4];
        int tick_at;
        logic [7:0] pat [4] = '{8'h4F, 8'h6D, 8'h06, 8'h5B};
        logic [3:0] one = 4'b0001;
        display_num = 16'h2153; blank_lz = 0; brightness = 4'd15; dp_in = 4'h0;
        wait_tick(ok);
        wait_tick(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL scan_tick_timeout got none want frame_tick"); end
        cnt = '{0, 0, 0, 0};
        tick_at = -1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (frame_tick && tick_at < 0) tick_at = k;
            for (int d = 0; d < 4; d++)
                if (dtube_cs_n === ~(one << d) && dtube_data === pat[d]) cnt[d]++;
            checks++;
            if ({dtube_cs_n, dtube_data, frame_tick} !== {ecs, edata, etick}) begin
                failures++;
                $display("FAIL scan k=%0d got cs=%b data=%h tick=%b want cs=%b data=%h tick=%b",
                         k, dtube_cs_n, dtube_data, frame_tick, ecs, edata, etick);
            end
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (cnt[d] !== 15) begin
                failures++;
                $display("FAIL scan_slot_len digit=%0d got %0d want 15", d, cnt[d]);
            end
        end
        checks++;
        if (tick_at !== 64) begin
            failures++;
            $display("FAIL tick_period got %0d want 64", tick_at);
        end
    endtask

    task automatic test_blank();
        bit ok;
        int hi_sel, u_cnt, dp_cnt;
        display_num = 16'h0007; blank_lz = 1; brightness = 4'd15; dp_in = 4'h0;
        wait_tick(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL blank_tick_timeout got none want frame_tick"); end
        hi_sel = 0; u_cnt = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (dtube_cs_n[3:1] !== 3'b111) hi_sel++;
            if (dtube_cs_n === 4'b1110 && dtube_data === 8'h07) u_cnt++;
            checks++;
            if ({dtube_cs_n, dtube_data, frame_tick} !== {ecs, edata, etick}) begin
                failures++;
                $display("FAIL blank k=%0d got cs=%b data=%h want cs=%b data=%h",
                         k, dtube_cs_n, dtube_data, ecs, edata);
            end
        end
        checks++;
        if (hi_sel !== 0 || u_cnt !== 15) begin
            failures++;
            $display("FAIL blank_select got hi=%0d units=%0d want hi=0 units=15", hi_sel, u_cnt);
        end
        dp_in = 4'b0100;
        wait_tick(ok);
        dp_cnt = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (dtube_cs_n === 4'b1011 && dtube_data === 8'h80) dp_cnt++;
        end
        checks++;
        if (dp_cnt !== 15) begin
            failures++;
            $display("FAIL blank_dp got %0d cycles of cs=1011/80 want 15", dp_cnt);
        end
    endtask

    task automatic test_midframe();
        bit ok;
        int early, late;
        display_num = 16'h1006; blank_lz = 0; brightness = 4'd15; dp_in = 4'h0;
        wait_tick(ok);
        wait_tick(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_tick_timeout got none want frame_tick"); end
        early = 0; late = 0;
        for (int k = 1; k <= 128; k++) begin
            @(negedge clk);
            if (k == 20) display_num = 16'h2153;
            if (dtube_cs_n === 4'b1110 && dtube_data === 8'h4F) begin
                if (k <= 64) early++; else late++;
            end
            checks++;
            if ({dtube_cs_n, dtube_data, frame_tick} !== {ecs, edata, etick}) begin
                failures++;
                $display("FAIL midframe k=%0d got cs=%b data=%h tick=%b want cs=%b data=%h tick=%b",
                         k, dtube_cs_n, dtube_data, frame_tick, ecs, edata, etick);
            end
        end
        checks++;
        if (early !== 0 || late !== 15) begin
            failures++;
            $display("FAIL midframe_tear got early=%0d late=%0d want early=0 late=15", early, late);
        end
    endtask

    task automatic test_bright();
        bit ok;
        int cnt [4];
        display_num = 16'($urandom); blank_lz = 0; brightness = 4'd3; dp_in = 4'($urandom);
        wait_tick(ok);
        wait_tick(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bright_tick_timeout got none want frame_tick"); end
        cnt = '{0, 0, 0, 0};
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) if (dtube_cs_n[d] === 1'b0) cnt[d]++;
            checks++;
            if ({dtube_cs_n, dtube_data, frame_tick} !== {ecs, edata, etick}) begin
                failures++;
                $display("FAIL bright k=%0d got cs=%b data=%h want cs=%b data=%h",
                         k, dtube_cs_n, dtube_data, ecs, edata);
            end
        end
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (cnt[d] !== 3) begin
                failures++;
                $display("FAIL bright_on_time digit=%0d got %0d want 3", d, cnt[d]);
            end
        end
    endtask

    task automatic test_hex();
        bit ok;
        int c0, c1;
        display_num = 16'h00AF; blank_lz = 0; brightness = 4'd15; dp_in = 4'h0;
        wait_tick(ok);
        wait_tick(ok);
        c0 = 0; c1 = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (dtube_cs_n === 4'b1110) c0++;
            if (dtube_cs_n === 4'b1101) c1++;
            checks++;
            if ({dtube_cs_n, dtube_data, frame_tick} !== {ecs, edata, etick}) begin
                failures++;
                $display("FAIL hex k=%0d got cs=%b data=%h want cs=%b data=%h",
                         k, dtube_cs_n, dtube_data, ecs, edata);
            end
        end
        checks++;
        if (c0 !== 15 || c1 !== 15) begin
            failures++;
            $display("FAIL hex_select got d0=%0d d1=%0d want 15 15", c0, c1);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 10; it++) begin
            @(negedge clk);
            display_num = 16'($urandom);
            if ($urandom_range(0, 1) == 1) display_num = display_num & 16'h00FF;
            dp_in = 4'($urandom); blank_lz = 1'($urandom); brightness = 4'($urandom);
            n = int'($urandom_range(5, 150));
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                checks++;
                if ({dtube_cs_n, dtube_data, frame_tick} !== {ecs, edata, etick}
                    || $countones(~dtube_cs_n) > 1) begin
                    failures++;
                    $display("FAIL random it=%0d k=%0d got cs=%b data=%h tick=%b want cs=%b data=%h tick=%b",
                             it, k, dtube_cs_n, dtube_data, frame_tick, ecs, edata, etick);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        display_num = 16'h8888; brightness = 4'd15; blank_lz = 0; dp_in = 4'hF;
        repeat (int'($urandom_range(70, 120))) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dtube_cs_n !== 4'hF || dtube_data !== 8'h00 || frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got cs=%b data=%h tick=%b want cs=1111 data=00 tick=0",
                     dtube_cs_n, dtube_data, frame_tick);
        end
        rst = 1'b0;
        for (int k = 0; k < 140; k++) begin
            @(negedge clk);
            checks++;
            if ({dtube_cs_n, dtube_data, frame_tick} !== {ecs, edata, etick}) begin
                failures++;
                $display("FAIL after_reset k=%0d got cs=%b data=%h tick=%b want cs=%b data=%h tick=%b",
                         k, dtube_cs_n, dtube_data, frame_tick, ecs, edata, etick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank();
        test_midframe();
        test_bright();
        test_hex();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
